// File: rtl/sdram_writer_pkg.sv
// Shared types and helpers for the SDRAM burst writer: FSM state encoding,
// Avalon burstcount width and the burst-length selection function.
package sdram_writer_pkg;

  localparam int BURSTCOUNT_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Beats for the next burst: a full burst, or whatever remains if less.
  function automatic logic [BURSTCOUNT_W-1:0] min_beats(input int burst_len,
                                                        input logic [63:0] remaining);
    if (remaining >= 64'(burst_len)) return BURSTCOUNT_W'(burst_len);
    return BURSTCOUNT_W'(remaining);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered fill level.
// Pushes when full and pops when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop_ok) level_d = level_q + (AW+1)'(1);
    else if (pop_ok && !push_ok) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/sdram_burst_writer.sv
// Stream-to-Avalon-MM burst write engine feeding the HPS SDRAM port.
// Optional perf counters are enabled with `define SDRAM_BURST_WRITER_PERF_EN.
module sdram_burst_writer
  import sdram_writer_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 32,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_W      = 24
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic                    cfg_start,
  input  logic [ADDR_W-1:0]       cfg_base_addr,
  input  logic [CNT_W-1:0]        cfg_word_count,
  output logic                    status_busy,
  output logic                    status_done,
  input  logic                    snk_valid,
  output logic                    snk_ready,
  input  logic [DATA_W-1:0]       snk_data,
  output logic [ADDR_W-1:0]       avm_address,
  output logic                    avm_write,
  output logic [DATA_W-1:0]       avm_writedata,
  output logic [DATA_W/8-1:0]     avm_byteenable,
  output logic [BURSTCOUNT_W-1:0] avm_burstcount,
  input  logic                    avm_waitrequest
`ifdef SDRAM_BURST_WRITER_PERF_EN
  ,
  output logic [31:0]             perf_stall_cycles,
  output logic [31:0]             perf_busy_cycles
`endif
);

  localparam int BYTES = DATA_W / 8;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [CNT_W-1:0]        rem_wr_q, rem_wr_d;
  logic [CNT_W-1:0]        rem_acc_q, rem_acc_d;
  logic [BURSTCOUNT_W-1:0] beats_q, beats_d;
  logic [BURSTCOUNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic                    fifo_full, fifo_empty, push, take;
  logic [LVL_W-1:0]        fifo_level;
  logic [DATA_W-1:0]       fifo_rdata;
  logic [BURSTCOUNT_W-1:0] fill_beats;

  assign status_busy    = (state_q != IDLE);
  assign status_done    = (state_q == DONE);
  assign snk_ready      = status_busy & ~fifo_full & (rem_acc_q != '0);
  assign push           = snk_valid & snk_ready;
  assign avm_write      = (state_q == BURST);
  assign take           = avm_write & ~avm_waitrequest;
  assign avm_address    = addr_q;
  assign avm_burstcount = beats_q;
  assign avm_byteenable = '1;
  // Gated so write data reads as zero outside bursts, including during reset.
  assign avm_writedata  = avm_write ? fifo_rdata : '0;
  assign fill_beats     = min_beats(BURST_LEN, 64'(rem_wr_q));

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_clk),
    .rst_ni  (reset_reset_n),
    .push_i  (push),
    .wdata_i (snk_data),
    .pop_i   (take & ~fifo_empty),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // A zero-count start still passes through FILL, which puts the done
  // pulse two cycles after the start with no writes issued.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_wr_d   = rem_wr_q;
    rem_acc_d  = rem_acc_q;
    beats_d    = beats_q;
    beat_cnt_d = beat_cnt_q;
    if (push) rem_acc_d = rem_acc_q - CNT_W'(1);
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          addr_d    = cfg_base_addr;
          rem_wr_d  = cfg_word_count;
          rem_acc_d = cfg_word_count;
          state_d   = FILL;
        end
      end
      FILL: begin
        if (rem_wr_q == '0) begin
          state_d = DONE;
        end else if (32'(fifo_level) >= 32'(fill_beats)) begin
          beats_d    = fill_beats;
          beat_cnt_d = fill_beats;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (take) begin
          beat_cnt_d = beat_cnt_q - BURSTCOUNT_W'(1);
          rem_wr_d   = rem_wr_q - CNT_W'(1);
          if (beat_cnt_q == BURSTCOUNT_W'(1)) begin
            addr_d  = addr_q + ADDR_W'(beats_q) * ADDR_W'(BYTES);
            state_d = (rem_wr_q == CNT_W'(1)) ? DONE : FILL;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_wr_q   <= '0;
      rem_acc_q  <= '0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_wr_q   <= rem_wr_d;
      rem_acc_q  <= rem_acc_d;
      beats_q    <= beats_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef SDRAM_BURST_WRITER_PERF_EN
  logic [31:0] stall_cnt_q, busy_cnt_q;

  // Saturating counters, cleared when a start is accepted.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stall_cnt_q <= '0;
      busy_cnt_q  <= '0;
    end else if (cfg_start && state_q == IDLE) begin
      stall_cnt_q <= '0;
      busy_cnt_q  <= '0;
    end else begin
      if (avm_write && avm_waitrequest && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (status_busy && busy_cnt_q != '1) busy_cnt_q <= busy_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_busy_cycles  = busy_cnt_q;
`endif

endmodule

// File: tb/tb_sdram_burst_writer.sv
// Scoreboard bench for sdram_burst_writer: accepted stream words are queued
// with their expected burst address/length and matched against Avalon beats.
module tb_sdram_burst_writer;

  typedef struct {
    logic [31:0] addr;
    logic [6:0]  bc;
    logic [63:0] data;
  } beat_t;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_base_addr = '0;
  logic [23:0] cfg_word_count = '0;
  logic        status_busy, status_done;
  logic        snk_valid = 1'b0;
  logic        snk_ready;
  logic [63:0] snk_data = '0;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [63:0] avm_writedata;
  logic [7:0]  avm_byteenable;
  logic [6:0]  avm_burstcount;
  logic        avm_waitrequest = 1'b0;
`ifdef SDRAM_BURST_WRITER_PERF_EN
  logic [31:0] perfStall, perfBusy;
`endif

  int vectorCount = 0, missCount = 0;
  beat_t sbQ[$];
  logic [31:0] xferBase = '0;
  int xferCount = 0, acceptIdx = 0, beatsTaken = 0, streamTotal = 0, wordsSent = 0;
  int gapEvery = 0, gapLen = 0, sinceGap = 0, gapCnt = 0;
  int stallBeat = -1, stallLeft = 0, stallSeen = 0, doneCount = 0, burstLeft = 0;
  int cycleCnt = 0, lastTakeCycle = 0, busyCycles = 0, doneAt = 0;
  bit accFlag = 0, prevStalled = 0;
  logic [31:0] heldAddr;
  logic [6:0]  heldBc;
  logic [63:0] heldData;

  sdram_burst_writer dut (
    .clk_clk        (clk_clk),
    .reset_reset_n  (reset_reset_n),
    .cfg_start      (cfg_start),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_word_count (cfg_word_count),
    .status_busy    (status_busy),
    .status_done    (status_done),
    .snk_valid      (snk_valid),
    .snk_ready      (snk_ready),
    .snk_data       (snk_data),
    .avm_address    (avm_address),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_byteenable (avm_byteenable),
    .avm_burstcount (avm_burstcount),
    .avm_waitrequest(avm_waitrequest)
`ifdef SDRAM_BURST_WRITER_PERF_EN
    ,
    .perf_stall_cycles(perfStall),
    .perf_busy_cycles (perfBusy)
`endif
  );

  always #5 clk_clk = ~clk_clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Monitor: observes outputs mid-cycle and scores beats/accepts for the coming edge.
  always begin
    @(negedge clk_clk);
    if (!reset_reset_n) begin
      accFlag = 0; burstLeft = 0; prevStalled = 0;
    end else begin
      cycleCnt++;
      if (status_busy) busyCycles++;
      if (burstLeft > 0) checkOutput("noBubble", 64'(avm_write), 64'd1);
      if (avm_write) begin
        if (burstLeft == 0) begin
          checkOutput("levelAtStart", 64'(sbQ.size() >= int'(avm_burstcount)), 64'd1);
          checkOutput("byteEnable", 64'(avm_byteenable), 64'hFF);
          burstLeft = int'(avm_burstcount);
        end
        if (prevStalled) begin
          checkOutput("holdAddr", 64'(avm_address), 64'(heldAddr));
          checkOutput("holdBurstcount", 64'(avm_burstcount), 64'(heldBc));
          checkOutput("holdData", avm_writedata, heldData);
        end
        if (avm_waitrequest) begin
          stallSeen++;
          if (stallLeft > 0) stallLeft--;
          prevStalled = 1;
          heldAddr = avm_address; heldBc = avm_burstcount; heldData = avm_writedata;
        end else begin
          prevStalled = 0;
          if (sbQ.size() == 0) checkOutput("sbEmpty", 64'd1, 64'd0);
          else begin
            beat_t e;
            e = sbQ.pop_front();
            checkOutput("addr", 64'(avm_address), 64'(e.addr));
            checkOutput("burstcount", 64'(avm_burstcount), 64'(e.bc));
            checkOutput("data", avm_writedata, e.data);
          end
          beatsTaken++; burstLeft--; lastTakeCycle = cycleCnt;
        end
      end
      if (status_done) begin
        doneCount++;
        if (xferCount > 0) checkOutput("doneAfterLastBeat", 64'(cycleCnt), 64'(lastTakeCycle + 1));
      end
      if (snk_valid && snk_ready) begin
        beat_t e;
        int grp, left;
        grp = acceptIdx / 8;
        left = xferCount - grp * 8;
        e.addr = xferBase + 32'(grp * 64);
        e.bc = 7'((left > 8) ? 8 : left);
        e.data = snk_data;
        sbQ.push_back(e);
        acceptIdx++;
        accFlag = 1;
      end else accFlag = 0;
    end
  end

  // Stream and waitrequest driver, updated just after each rising edge.
  always begin
    @(posedge clk_clk);
    #1;
    if (accFlag) begin wordsSent++; sinceGap++; end
    if (gapEvery > 0 && accFlag && sinceGap == gapEvery) begin gapCnt = gapLen; sinceGap = 0; end
    if (gapCnt > 0) begin
      snk_valid = 1'b0; gapCnt--;
    end else if (wordsSent < streamTotal) begin
      if (!snk_valid || accFlag) snk_data = {$urandom, $urandom};
      snk_valid = 1'b1;
    end else snk_valid = 1'b0;
    avm_waitrequest = (stallLeft > 0 && beatsTaken == stallBeat) ? 1'b1 : 1'b0;
  end

  task automatic startXfer(input logic [31:0] base, input int count, input int offered,
                           input int gEvery, input int gLen, input int sBeat, input int sLen);
    @(posedge clk_clk); #2;
    xferBase = base; xferCount = count; acceptIdx = 0; beatsTaken = 0; wordsSent = 0;
    streamTotal = offered; gapEvery = gEvery; gapLen = gLen; sinceGap = 0; gapCnt = 0;
    stallBeat = sBeat; stallLeft = sLen; stallSeen = 0; doneCount = 0; busyCycles = 0;
    cfg_base_addr = base; cfg_word_count = 24'(count); cfg_start = 1'b1;
    @(posedge clk_clk); #2;
    cfg_start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] base, input int count, input int offered,
                               input int gEvery, input int gLen, input int sBeat, input int sLen);
    startXfer(base, count, offered, gEvery, gLen, sBeat, sLen);
    doneAt = -1;
    for (int k = 1; k <= 600 && doneAt < 0; k++) begin
      @(negedge clk_clk);
      if (status_done) doneAt = k;
    end
    if (doneAt < 0) checkOutput("doneTimeout", 64'd0, 64'd1);
    repeat (3) @(negedge clk_clk);
    checkOutput("beatsWritten", 64'(beatsTaken), 64'(count));
    checkOutput("wordsAccepted", 64'(acceptIdx), 64'(count));
    checkOutput("donePulses", 64'(doneCount), 64'd1);
    checkOutput("sbDrained", 64'(sbQ.size()), 64'd0);
  endtask

  task automatic checkResetOutputs(input string phase);
    checkOutput({phase, "Write"}, 64'(avm_write), 64'd0);
    checkOutput({phase, "Address"}, 64'(avm_address), 64'd0);
    checkOutput({phase, "Burstcount"}, 64'(avm_burstcount), 64'd0);
    checkOutput({phase, "Writedata"}, avm_writedata, 64'd0);
    checkOutput({phase, "Busy"}, 64'(status_busy), 64'd0);
    checkOutput({phase, "Done"}, 64'(status_done), 64'd0);
    checkOutput({phase, "Ready"}, 64'(snk_ready), 64'd0);
    checkOutput({phase, "ByteEnable"}, 64'(avm_byteenable), 64'hFF);
  endtask

  initial begin
    #12;
    checkResetOutputs("rst");
    repeat (2) @(posedge clk_clk);
    #2 reset_reset_n = 1'b1;

    // Two full bursts, continuous stream.
    applyStimulus(32'h1000_0000, 16, 16, 0, 0, -1, 0);
`ifdef SDRAM_BURST_WRITER_PERF_EN
    checkOutput("perfBusy", 64'(perfBusy), 64'(busyCycles));
`endif

    // Partial final burst; a 12th word is offered but must be refused.
    applyStimulus(32'h2000_0100, 11, 12, 0, 0, -1, 0);
    checkOutput("extraValid", 64'(snk_valid), 64'd1);
    checkOutput("extraRefused", 64'(snk_ready), 64'd0);
    streamTotal = 0;

    // Five-cycle waitrequest on beat index 3.
    applyStimulus(32'h3000_0000, 16, 16, 0, 0, 3, 5);
    checkOutput("stallCycles", 64'(stallSeen), 64'd5);
`ifdef SDRAM_BURST_WRITER_PERF_EN
    checkOutput("perfStall", 64'(perfStall), 64'd5);
`endif

    // Bursty stream: 2 words then a 4-cycle gap.
    applyStimulus(32'h4000_0000, 16, 16, 2, 4, -1, 0);

    // Zero-count transfer.
    applyStimulus(32'h5000_0000, 0, 4, 0, 0, -1, 0);
    checkOutput("zeroDoneCycle", 64'(doneAt), 64'd2);
    streamTotal = 0;

    // Reset in the middle of the first burst, then a clean 8-word transfer.
    startXfer(32'h6000_0000, 16, 16, 0, 0, -1, 0);
    for (int k = 0; k < 200 && beatsTaken < 3; k++) @(negedge clk_clk);
    checkOutput("reachedMidBurst", 64'(beatsTaken >= 3), 64'd1);
    @(posedge clk_clk); #2;
    reset_reset_n = 1'b0;
    streamTotal = 0;
    #1;
    checkResetOutputs("midRst");
    sbQ.delete();
    repeat (3) @(posedge clk_clk);
    #2 reset_reset_n = 1'b1;
    @(negedge clk_clk);
    checkOutput("postRstBusy", 64'(status_busy), 64'd0);
    applyStimulus(32'h6000_1000, 8, 8, 0, 0, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
